// File: rtl/biquad_pkg.sv
// Shared types and helpers for the cascaded biquad equaliser.
// Holds coefficient slot names, FSM state codes and the fixed-point round/saturate helper.
// Purely declarative; no logic of its own.
package biquad_pkg;

   // Coefficient slot order inside each band's bank; also the MAC tap order
   typedef enum logic [2:0] {
      C_B0 = 3'd0,
      C_B1 = 3'd1,
      C_B2 = 3'd2,
      C_A1 = 3'd3,
      C_A2 = 3'd4
   } coef_sel_e;

   localparam int NCOEF = 5;

   // FSM state codes
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_MAC    = 3'd1;
   localparam state_t S_NORM   = 3'd2;
   localparam state_t S_OUT    = 3'd3;
   localparam state_t S_COMMIT = 3'd4;

   // Working width for the round/saturate helper; must exceed the accumulator width
   localparam int SAT_W = 64;

   // Identity coefficient (1.0) for a given number of fraction bits
   function automatic logic [31:0] coef_ident(input int frac);
      return 32'd1 << frac;
   endfunction

   // Round half up at the binary point, then clamp to the signed dw-bit range
   function automatic logic signed [SAT_W-1:0] sat_round(input logic signed [SAT_W-1:0] acc,
                                                         input int frac, input int dw);
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (r > hi)
         return hi;
      else if (r < lo)
         return lo;
      else
         return r;
   endfunction

endpackage

// File: rtl/biquad_mac.sv
// Signed coefficient x sample multiply-accumulate with clear and subtract controls.
// Latency: one cycle, the accumulator register is the output.
// No backpressure; accumulates only when i_en is high.
module biquad_mac #(
   parameter int DW   = 24,
   parameter int CW   = 18,
   parameter int ACCW = DW + CW + 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   input  logic                   i_clr,
   input  logic                   i_sub,
   input  logic signed [CW-1:0]   i_coef,
   input  logic signed [DW-1:0]   i_samp,
   output logic signed [ACCW-1:0] o_acc
);

   logic signed [CW+DW-1:0] prod;
   logic signed [ACCW-1:0]  prod_ext;
   logic signed [ACCW-1:0]  base;
   logic signed [ACCW-1:0]  acc_nxt;

   // Full-precision product, sign-extended to the accumulator width
   assign prod     = (CW+DW)'(i_coef) * (CW+DW)'(i_samp);
   assign prod_ext = ACCW'(prod);

   // Clear restarts the sum from zero; feedback taps subtract
   always_comb begin
      base    = i_clr ? '0 : o_acc;
      acc_nxt = i_sub ? (base - prod_ext) : (base + prod_ext);
   end

   // Accumulator register
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_acc <= '0;
      else if (i_en)
         o_acc <= acc_nxt;
   end

endmodule

// File: rtl/biquad_cascade.sv
// N-band Direct Form I biquad cascade sharing one MAC, with shadow/active coefficient banks.
// Latency: 6 cycles per active band, 1 per bypassed band, plus 1 output cycle (25 at NBAND=4).
// o_ready drops from the cycle after accept until the cycle after o_valid (plus one if a commit is pending).
module biquad_cascade
   import biquad_pkg::*;
#(
   parameter int DW    = 24,
   parameter int CW    = 18,
   parameter int FRAC  = 15,
   parameter int NBAND = 4,
   parameter int ACCW  = DW + CW + 4
) (
   input  logic                                         i_clk,
   input  logic                                         i_rst,
   input  logic signed [DW-1:0]                         i_data,
   input  logic                                         i_valid,
   output logic                                         o_ready,
   input  logic [NBAND-1:0]                             i_bypass,
   output logic signed [DW-1:0]                         o_data,
   output logic                                         o_valid,
   input  logic                                         i_coef_we,
   input  logic [((NBAND > 1) ? $clog2(NBAND) : 1)-1:0] i_coef_band,
   input  logic [2:0]                                   i_coef_sel,
   input  logic signed [CW-1:0]                         i_coef_data,
   input  logic                                         i_coef_commit
);

   localparam int BW = (NBAND > 1) ? $clog2(NBAND) : 1;
   localparam logic signed [CW-1:0] COEF_ONE  = CW'(coef_ident(FRAC));
   localparam logic [BW-1:0]        LAST_BAND = BW'(NBAND - 1);

   state_t               state;
   logic [BW-1:0]        band;
   logic [BW-1:0]        nxt_band;
   logic [2:0]           tap;
   logic [NBAND-1:0]     byp;
   logic signed [DW-1:0] x_cur;
   logic                 pending;

   logic signed [CW-1:0] coef_sh  [NBAND][NCOEF];
   logic signed [CW-1:0] coef_act [NBAND][NCOEF];
   logic signed [DW-1:0] x1 [NBAND];
   logic signed [DW-1:0] x2 [NBAND];
   logic signed [DW-1:0] y1 [NBAND];
   logic signed [DW-1:0] y2 [NBAND];

   logic signed [CW-1:0]   mac_coef;
   logic signed [DW-1:0]   mac_samp;
   logic                   mac_en;
   logic                   mac_clr;
   logic                   mac_sub;
   logic signed [ACCW-1:0] mac_acc;
   logic signed [DW-1:0]   y_band;

   assign o_ready  = (state == S_IDLE) && !pending;
   assign nxt_band = band + 1'b1;
   assign mac_en   = (state == S_MAC);
   assign mac_clr  = (tap == 3'd0);
   assign mac_sub  = (tap >= 3'd3);

   // Select the coefficient and history operand for the current tap of the current band
   always_comb begin
      mac_coef = coef_act[band][C_B0];
      mac_samp = x_cur;
      case (tap)
         C_B0: begin mac_coef = coef_act[band][C_B0]; mac_samp = x_cur;    end
         C_B1: begin mac_coef = coef_act[band][C_B1]; mac_samp = x1[band]; end
         C_B2: begin mac_coef = coef_act[band][C_B2]; mac_samp = x2[band]; end
         C_A1: begin mac_coef = coef_act[band][C_A1]; mac_samp = y1[band]; end
         C_A2: begin mac_coef = coef_act[band][C_A2]; mac_samp = y2[band]; end
         default: begin mac_coef = '0; mac_samp = '0; end
      endcase
   end

   // Band output: rounded/saturated sum, or the untouched input when bypassed
   always_comb begin
      y_band = DW'(sat_round(SAT_W'(mac_acc), FRAC, DW));
      if (byp[band])
         y_band = x_cur;
   end

   biquad_mac #(
      .DW   (DW),
      .CW   (CW),
      .ACCW (ACCW)
   ) u_mac (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (mac_en),
      .i_clr  (mac_clr),
      .i_sub  (mac_sub),
      .i_coef (mac_coef),
      .i_samp (mac_samp),
      .o_acc  (mac_acc)
   );

   // Shadow bank takes writes any time; active bank only changes in COMMIT, between samples
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int b = 0; b < NBAND; b++) begin
            for (int c = 0; c < NCOEF; c++) begin
               coef_sh[b][c]  <= (c == 0) ? COEF_ONE : '0;
               coef_act[b][c] <= (c == 0) ? COEF_ONE : '0;
            end
         end
      end else begin
         if (i_coef_we && (i_coef_sel <= C_A2) && (int'(i_coef_band) < NBAND))
            coef_sh[i_coef_band][i_coef_sel] <= i_coef_data;
         if (state == S_COMMIT)
            coef_act <= coef_sh;
      end
   end

   // Per-band delay lines advance once per sample, skipped for bypassed bands
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int b = 0; b < NBAND; b++) begin
            x1[b] <= '0;
            x2[b] <= '0;
            y1[b] <= '0;
            y2[b] <= '0;
         end
      end else if ((state == S_NORM) && !byp[band]) begin
         x2[band] <= x1[band];
         x1[band] <= x_cur;
         y2[band] <= y1[band];
         y1[band] <= y_band;
      end
   end

   // Sequencer: accept, walk bands/taps, emit, and apply pending commits between samples
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         band    <= '0;
         tap     <= '0;
         byp     <= '0;
         x_cur   <= '0;
         pending <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= 1'b0;
         // A request seen during COMMIT survives so a write landing there is not lost
         if (i_coef_commit)
            pending <= 1'b1;
         else if (state == S_COMMIT)
            pending <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pending) begin
                  state <= S_COMMIT;
               end else if (i_valid) begin
                  x_cur <= i_data;
                  byp   <= i_bypass;
                  band  <= '0;
                  tap   <= '0;
                  state <= i_bypass[0] ? S_NORM : S_MAC;
               end
            end
            S_MAC: begin
               if (tap == 3'd4) begin
                  tap   <= '0;
                  state <= S_NORM;
               end else begin
                  tap <= tap + 3'd1;
               end
            end
            S_NORM: begin
               x_cur <= y_band;
               if (band == LAST_BAND) begin
                  o_data  <= y_band;
                  o_valid <= 1'b1;
                  state   <= S_OUT;
               end else begin
                  band  <= nxt_band;
                  state <= byp[nxt_band] ? S_NORM : S_MAC;
               end
            end
            S_OUT:    state <= pending ? S_COMMIT : S_IDLE;
            S_COMMIT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_biquad_cascade.sv
// Scoreboard bench for biquad_cascade: directed samples push expected value and latency,
// a monitor pops and compares on every o_valid.
// Covers identity, gain/rounding, recursion, saturation, commit timing, bypass, throughput, abort.
module tb_biquad_cascade;

   localparam int DW    = 24;
   localparam int CW    = 18;
   localparam int NBAND = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] i_data;
   logic                 i_valid;
   logic                 o_ready;
   logic [NBAND-1:0]     i_bypass;
   logic signed [DW-1:0] o_data;
   logic                 o_valid;
   logic                 i_coef_we;
   logic [1:0]           i_coef_band;
   logic [2:0]           i_coef_sel;
   logic signed [CW-1:0] i_coef_data;
   logic                 i_coef_commit;

   typedef struct {
      logic signed [DW-1:0] d;
      int                   t0;
      int                   lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   acc_cyc [3];

   biquad_cascade #(.DW(DW), .CW(CW), .FRAC(15), .NBAND(NBAND)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_bypass      (i_bypass),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .i_coef_we     (i_coef_we),
      .i_coef_band   (i_coef_band),
      .i_coef_sel    (i_coef_sel),
      .i_coef_data   (i_coef_data),
      .i_coef_commit (i_coef_commit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: every output strobe must match the oldest outstanding expectation
   task automatic mon_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", longint'(o_data), 0);
               chk("unexpected_valid_strobe", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("o_data", longint'(o_data), longint'(e.d));
               chk("latency", cyc - e.t0, e.lat);
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wcoef(input int b, input int sel, input int val, input bit cmt);
      @(negedge clk);
      i_coef_we     = 1'b1;
      i_coef_band   = 2'(b);
      i_coef_sel    = 3'(sel);
      i_coef_data   = CW'(val);
      i_coef_commit = cmt;
      @(negedge clk);
      i_coef_we     = 1'b0;
      i_coef_commit = 1'b0;
   endtask

   // Offer one sample; optionally record the expected result and latency
   task automatic send(input int d, input logic [3:0] byp, input bit cmt,
                       input bit track, input int expd, input int lat);
      exp_t e;
      int   w;
      w = 0;
      @(negedge clk);
      while (!o_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!o_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      i_data        = DW'(d);
      i_bypass      = byp;
      i_valid       = 1'b1;
      i_coef_commit = cmt;
      if (track) begin
         e.d   = DW'(expd);
         e.t0  = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      i_valid       = 1'b0;
      i_coef_commit = 1'b0;
      i_bypass      = '0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("outstanding_after_drain", sb.size(), 0);
   endtask

   initial begin
      int vals [3];
      int exps [3];
      int k;
      int w;
      int cnt;
      exp_t e;

      rst = 1'b1;
      i_data = '0; i_valid = 1'b0; i_bypass = '0;
      i_coef_we = 1'b0; i_coef_band = '0; i_coef_sel = '0; i_coef_data = '0; i_coef_commit = 1'b0;
      fork
         mon_loop();
      join_none
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_o_valid", o_valid, 0);
      chk("reset_o_data", longint'(o_data), 0);
      chk("reset_o_ready", o_ready, 1);

      // Identity coefficients after reset
      send(1000, 4'b0000, 0, 1, 1000, 25);
      send(-8388608, 4'b0000, 0, 1, -8388608, 25);
      drain();

      // Gain 0.5 on band 0 with round-half-up
      wcoef(0, 0, 16384, 1);
      send(1000, 4'b0000, 0, 1, 500, 25);
      send(3, 4'b0000, 0, 1, 2, 25);
      send(-3, 4'b0000, 0, 1, -1, 25);
      // Bypass: all bands, then only the halving band
      send(777, 4'b1111, 0, 1, 777, 5);
      send(1000, 4'b0001, 0, 1, 1000, 20);
      drain();

      // Recursion y = x + 0.5*y1; write and commit in the same cycle
      do_reset();
      wcoef(0, 3, -16384, 1);
      send(1024, 4'b0000, 0, 1, 1024, 25);
      send(0, 4'b0000, 0, 1, 512, 25);
      send(0, 4'b0000, 0, 1, 256, 25);
      send(0, 4'b0000, 0, 1, 128, 25);
      send(0, 4'b0000, 0, 1, 64, 25);
      drain();

      // Saturation with gain 3.0; commit issued with the first sample applies only afterwards
      do_reset();
      wcoef(0, 0, 98304, 0);
      send(4000000, 4'b0000, 1, 1, 4000000, 25);
      send(4000000, 4'b0000, 0, 1, 8388607, 25);
      send(-4000000, 4'b0000, 0, 1, -8388608, 25);
      drain();

      // Commit while busy: sample keeps old b0, ready held low one extra cycle
      do_reset();
      wcoef(0, 0, 16384, 0);
      send(1000, 4'b0000, 0, 1, 1000, 25);
      repeat (3) @(negedge clk);
      i_coef_commit = 1'b1;
      @(negedge clk);
      i_coef_commit = 1'b0;
      w = 0;
      while (!o_valid && w < 60) begin
         @(negedge clk);
         w++;
      end
      chk("busy_commit_valid_seen", o_valid, 1);
      @(negedge clk);
      chk("ready_low_during_commit", o_ready, 0);
      @(negedge clk);
      chk("ready_high_after_commit", o_ready, 1);
      send(1000, 4'b0000, 0, 1, 500, 25);
      drain();

      // Back-to-back: i_valid held high, one accept every 26 cycles, b0 = 0.5 still active
      vals[0] = 11;  exps[0] = 6;
      vals[1] = -22; exps[1] = -11;
      vals[2] = 33;  exps[2] = 17;
      k = 0;
      w = 0;
      while (k < 3 && w < 200) begin
         @(negedge clk);
         w++;
         i_data  = DW'(vals[k]);
         i_valid = 1'b1;
         if (o_ready) begin
            acc_cyc[k] = cyc;
            e.d   = DW'(exps[k]);
            e.t0  = cyc;
            e.lat = 25;
            sb.push_back(e);
            k++;
         end
      end
      @(negedge clk);
      i_valid = 1'b0;
      chk("stream_accepts", k, 3);
      chk("stream_gap_0_1", acc_cyc[1] - acc_cyc[0], 26);
      chk("stream_gap_1_2", acc_cyc[2] - acc_cyc[1], 26);
      drain();

      // Reset mid-MAC aborts the sample and restores identity coefficients
      send(5000, 4'b0000, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      do_reset();
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_valid) cnt++;
      end
      chk("abort_no_valid", cnt, 0);
      send(1000, 4'b0000, 0, 1, 1000, 25);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/biquad_cascade.md
Name: biquad_cascade

Overview:
- N-band cascaded biquad equaliser: one time-multiplexed multiply-accumulate unit serves all bands.
- Parametrised in data width, coefficient width, fixed-point format and band count.
- Coefficients are loaded at run time through a double-buffered (shadow/active) write port, so updates apply atomically between samples.
- Sits between the audio sample source and the DAC/visualiser path; replaces single-band, fixed-frequency filtering.

Parameters:
- DW, 24: signed sample width.
- CW, 18: signed coefficient width.
- FRAC, 15: coefficient fraction bits. Coefficient value = integer / 2^FRAC.
- NBAND, 4: number of cascaded bands, at least 1.
- ACCW, DW+CW+4: accumulator width.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset.
- i_data, in, DW: input sample, signed.
- i_valid, in, 1: input sample valid.
- o_ready, out, 1: block can accept a sample.
- i_bypass, in, NBAND: per-band bypass, sampled at accept.
- o_data, out, DW: output sample, signed, saturated.
- o_valid, out, 1: one-cycle output strobe.
- i_coef_we, in, 1: shadow coefficient write enable.
- i_coef_band, in, $clog2(NBAND) (min 1): band index.
- i_coef_sel, in, 3: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- i_coef_data, in, CW: coefficient value, signed.
- i_coef_commit, in, 1: request copy of shadow to active.

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset state:
  - o_valid=0, o_data=0, o_ready=1.
  - All shadow and active coefficients = identity (b0 = 1<<FRAC, others 0).
  - All history registers (x1, x2, y1, y2 per band) = 0; pending-commit flag = 0.
  - Reset mid-sample aborts the sample with no o_valid.
- Per-band filter (Direct Form I):
  - acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2.
  - y = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
  - y is saturated to the signed DW range.
  - The band's output is the next band's input.
- FSM states: IDLE, MAC, NORM, OUT, COMMIT.
- IDLE:
  - o_ready = 1 when the pending flag is 0.
  - i_valid & o_ready latches i_data and i_bypass; band=0, tap=0; go to MAC, or NORM if band 0 is bypassed.
  - Pending flag = 1 goes to COMMIT instead; o_ready=0 in that cycle.
- MAC: five cycles, tap 0..4, one multiply-accumulate each; the accumulator clears on tap 0. Then go to NORM.
- NORM: one cycle.
  - Round and saturate.
  - Shift history: x2<=x1, x1<=x, y2<=y1, y1<=y.
  - A bypassed band passes its input through unchanged and leaves its history untouched.
  - If band = NBAND-1, go to OUT; otherwise band+1 and go to MAC, or to NORM if that band is bypassed.
- OUT: register o_data and pulse o_valid for one cycle, then go to IDLE.
- Latency, no bypass: o_valid is high in cycle T+6*NBAND+1, where T is the accept cycle. Each bypassed band shortens this by 5 cycles. o_ready is low from T+1 until the cycle after o_valid.
- COMMIT: one cycle; all active coefficients <= shadow; pending flag cleared; go to IDLE.
- Coefficient writes:
  - i_coef_we writes the shadow copy in any state.
  - Writes with sel>4 or band>=NBAND are ignored.
- Commit requests:
  - i_coef_commit sets the pending flag in any state.
  - A commit arriving during a sample never alters that sample's coefficients.
  - Same-cycle write and commit: the write is included in the copy.
  - i_valid and i_coef_commit together in IDLE: the sample is accepted and uses the old coefficients; the commit applies after OUT.
- Coefficients and history are not cleared by commit.
- Arithmetic:
  - Products are sign-extended to ACCW.
  - Coefficients must be |c| < 2^(CW-1-FRAC), i.e. < 4.0 at defaults.

Decomposition:
- Package biquad_pkg holds:
  - the coefficient-index enum (B0, B1, B2, A1, A2);
  - the FSM state enum;
  - a sat_round function (acc, FRAC, DW);
  - the identity-coefficient constant.
- One sub-module, biquad_mac: signed CW x DW multiplier, ACCW accumulator with clear and subtract controls, registered output.

Test Plan:
- Identity: after reset, input 1000 -> o_data=1000, o_valid at accept+25 cycles (NBAND=4); input -8388608 -> -8388608.
- Gain and rounding: band0 b0=16384, commit; input 1000 -> 500; input 3 -> 2; input -3 -> -1.
- Recursion: band0 b0=32768, a1=-16384, commit; impulse 1024 then zeros -> 1024, 512, 256, 128, 64.
- Saturation: band0 b0=98304 (3.0); input 4000000 -> 8388607; input -4000000 -> -8388608.
- Commit during busy: assert commit mid-MAC with new b0=16384; that sample keeps b0=1.0; o_ready stays low one extra cycle after OUT; the next sample is halved.
- Bypass and throughput: i_bypass=4'b1111, input 777 -> 777 at accept+5; back-to-back i_valid with no bypass accepts one sample per 26 cycles with no loss; reset asserted mid-MAC -> no o_valid, identity restored.
